// File: rtl/cmult_pkg.sv
// Shared helpers for cmult_pipe: component slicing, round-half-up/saturate, pipeline latency.
package cmult_pkg;

  localparam int unsigned PIPE_LAT = 3;
  localparam int unsigned CMAX_W   = 64;
  localparam int unsigned ACC_W    = 2*CMAX_W + 4;

  typedef logic [CMAX_W-1:0]       comp_t;
  typedef logic [2*CMAX_W-1:0]     pair_t;
  typedef logic signed [ACC_W-1:0] acc_t;

  typedef struct packed {
    logic  ovf;
    comp_t val;
  } rs_t;

  function automatic comp_t comp_mask(input int unsigned w);
    comp_t m;
    m = '1;
    return m >> (CMAX_W - w);
  endfunction

  // Packing is {real, imag}; each helper returns the w-bit component zero-extended.
  function automatic comp_t cplx_re(input pair_t p, input int unsigned w);
    pair_t s;
    s = p >> w;
    return s[CMAX_W-1:0] & comp_mask(w);
  endfunction

  function automatic comp_t cplx_im(input pair_t p, input int unsigned w);
    return p[CMAX_W-1:0] & comp_mask(w);
  endfunction

  // Round half toward +inf at frac_w, then clamp to the signed data_w range.
  function automatic rs_t round_sat(input acc_t x, input int unsigned data_w,
                                    input int unsigned frac_w);
    acc_t r;
    acc_t hi;
    acc_t lo;
    rs_t  res;
    r = x;
    if (frac_w > 0)
      r = (x + (acc_t'(1) <<< (frac_w - 1))) >>> frac_w;
    hi = (acc_t'(1) <<< (data_w - 1)) - acc_t'(1);
    lo = -(acc_t'(1) <<< (data_w - 1));
    res.ovf = 1'b0;
    if (r > hi) begin
      res.val = hi[CMAX_W-1:0];
      res.ovf = 1'b1;
    end else if (r < lo) begin
      res.val = lo[CMAX_W-1:0];
      res.ovf = 1'b1;
    end else begin
      res.val = r[CMAX_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/cmult_round_sat.sv
// Combinational round-half-up plus saturate for one complex component, with clamp flag.
module cmult_round_sat
  import cmult_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned FRAC_W = 15,
  parameter int unsigned SUM_W  = 2*DATA_W + 2
) (
  input  logic signed [SUM_W-1:0] sum,
  output logic        [DATA_W-1:0] res,
  output logic                     ovf
);

  rs_t  rs;
  logic unused_hi;

  always_comb begin
    rs = round_sat(acc_t'(sum), DATA_W, FRAC_W);
  end

  assign res       = rs.val[DATA_W-1:0];
  assign ovf       = rs.ovf;
  assign unused_hi = ^rs.val[CMAX_W-1:DATA_W];

endmodule

// File: rtl/cmult_pipe.sv
// Pipelined fixed-point complex multiplier (a*b or a*conj(b)), 3-cycle latency, full-pipeline stall.
// Define CMULT_GAUSS3_EN to build stage 2 with the 3-multiplier Gauss form (bit-exact with the default).
module cmult_pipe
  import cmult_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned FRAC_W = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2*DATA_W-1:0] in_a,
  input  logic [2*DATA_W-1:0] in_b,
  input  logic                in_conj,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*DATA_W-1:0] out_data,
  output logic                out_ovf
);

  localparam int unsigned PROD_W = 2*DATA_W + 1;
  localparam int unsigned SUM_W  = 2*DATA_W + 2;

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  comp_t a_re_w, a_im_w, b_re_w, b_im_w;
  logic  unused_hi;
  assign a_re_w    = cplx_re(pair_t'(in_a), DATA_W);
  assign a_im_w    = cplx_im(pair_t'(in_a), DATA_W);
  assign b_re_w    = cplx_re(pair_t'(in_b), DATA_W);
  assign b_im_w    = cplx_im(pair_t'(in_b), DATA_W);
  assign unused_hi = ^{a_re_w[CMAX_W-1:DATA_W], a_im_w[CMAX_W-1:DATA_W],
                       b_re_w[CMAX_W-1:DATA_W], b_im_w[CMAX_W-1:DATA_W]};

  logic signed [DATA_W-1:0] a_re, a_im, b_re;
  logic signed [DATA_W:0]   b_im_x, b_imc;
  assign a_re   = a_re_w[DATA_W-1:0];
  assign a_im   = a_im_w[DATA_W-1:0];
  assign b_re   = b_re_w[DATA_W-1:0];
  // One extra bit keeps -(-2^(DATA_W-1)) exact.
  assign b_im_x = {b_im_w[DATA_W-1], b_im_w[DATA_W-1:0]};
  assign b_imc  = in_conj ? -b_im_x : b_im_x;

  logic v1, v2;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else if (adv) begin
      v1 <= in_valid;
      v2 <= v1;
    end
  end

  logic signed [SUM_W-1:0] sum_re, sum_im;
  logic signed [DATA_W-1:0] s1_ar, s1_ai, s1_br;

`ifdef CMULT_GAUSS3_EN
  logic signed [DATA_W+1:0] s1_sa, s1_db, s1_sb;
  logic signed [SUM_W-1:0]  k1, k2, k3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_ar <= '0; s1_ai <= '0; s1_br <= '0;
      s1_sa <= '0; s1_db <= '0; s1_sb <= '0;
    end else if (adv) begin
      s1_ar <= a_re;
      s1_ai <= a_im;
      s1_br <= b_re;
      s1_sa <= (DATA_W+2)'(a_re) + (DATA_W+2)'(a_im);
      s1_db <= (DATA_W+2)'(b_imc) - (DATA_W+2)'(b_re);
      s1_sb <= (DATA_W+2)'(b_re) + (DATA_W+2)'(b_imc);
    end
  end

  // Products are wrapped to SUM_W; the recombined sums are exact because the true results fit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k1 <= '0; k2 <= '0; k3 <= '0;
    end else if (adv) begin
      k1 <= SUM_W'(s1_br) * SUM_W'(s1_sa);
      k2 <= SUM_W'(s1_ar) * SUM_W'(s1_db);
      k3 <= SUM_W'(s1_ai) * SUM_W'(s1_sb);
    end
  end

  assign sum_re = k1 - k3;
  assign sum_im = k1 + k2;
`else
  logic signed [DATA_W:0]   s1_bi;
  logic signed [PROD_W-1:0] p_rr, p_ii, p_ri, p_ir;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_ar <= '0; s1_ai <= '0; s1_br <= '0; s1_bi <= '0;
    end else if (adv) begin
      s1_ar <= a_re;
      s1_ai <= a_im;
      s1_br <= b_re;
      s1_bi <= b_imc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_rr <= '0; p_ii <= '0; p_ri <= '0; p_ir <= '0;
    end else if (adv) begin
      p_rr <= PROD_W'(s1_ar) * PROD_W'(s1_br);
      p_ii <= PROD_W'(s1_ai) * PROD_W'(s1_bi);
      p_ri <= PROD_W'(s1_ar) * PROD_W'(s1_bi);
      p_ir <= PROD_W'(s1_ai) * PROD_W'(s1_br);
    end
  end

  assign sum_re = SUM_W'(p_rr) - SUM_W'(p_ii);
  assign sum_im = SUM_W'(p_ri) + SUM_W'(p_ir);
`endif

  logic [DATA_W-1:0] rs_re, rs_im;
  logic              ovf_re, ovf_im;

  cmult_round_sat #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .SUM_W(SUM_W)) u_rs_re (
    .sum (sum_re),
    .res (rs_re),
    .ovf (ovf_re)
  );

  cmult_round_sat #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .SUM_W(SUM_W)) u_rs_im (
    .sum (sum_im),
    .res (rs_im),
    .ovf (ovf_im)
  );

  // Bubbles clear out_valid but leave the last result on out_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
    end else if (adv) begin
      out_valid <= v2;
      if (v2) begin
        out_data <= {rs_re, rs_im};
        out_ovf  <= ovf_re | ovf_im;
      end
    end
  end

endmodule

// File: doc/cmult_pipe.md
Name: cmult_pipe

Overview:
- Pipelined, parametrised fixed-point complex multiplier for the FFT butterfly twiddle path. Replaces the combinational float multiplier stage.
- Accepts one operand pair per cycle on a valid/ready stream.
- Optional conjugate mode: per transaction, multiplies by conj(b).
- Output is rounded, saturated, and carries an overflow flag. Fixed latency is 3 cycles, with full-pipeline stall on backpressure.

Parameters:
- DATA_W, 16, width of each real/imag component (signed two's complement).
- FRAC_W, 15, fractional bits (Q1.15 at default); must satisfy FRAC_W < DATA_W.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  pipeline can accept input this cycle.
- in_a  in  2*DATA_W  operand a, {real[2*DATA_W-1:DATA_W], imag[DATA_W-1:0]}.
- in_b  in  2*DATA_W  operand b, same packing.
- in_conj  in  1  1: result = a*conj(b); 0: result = a*b.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  2*DATA_W  result, {real, imag}.
- out_ovf  out  1  either component saturated.

Behaviour:
- Reset: all stage valid bits, out_valid, out_data and out_ovf go to 0 asynchronously. In-flight data is discarded. in_ready = 1 after reset.
- Advance enable: adv = !out_valid || out_ready. in_ready = adv (combinational). All stages load only when adv = 1; bubbles are not compressed.
- Transfer: input accepted when in_valid && in_ready. Output consumed when out_valid && out_ready.
- Latency: an accepted input appears on out_data exactly 3 advancing cycles later. Throughput is 1 per cycle with out_ready held high.
- Stage 1: register operands and conj. Effective bi' = conj ? -bi : bi, computed at DATA_W+1 bits so -(-2^(DATA_W-1)) is exact.
- Stage 2: full-precision products ar*br, ai*bi', ar*bi', ai*br, each 2*DATA_W+1 bits.
- Stage 3 sums:
  - re = ar*br - ai*bi'
  - im = ar*bi' + ai*br
  - Both at 2*DATA_W+2 bits, no loss.
- Stage 3 rounding: round half toward +inf. Add 2^(FRAC_W-1), then arithmetic shift right by FRAC_W.
- Stage 3 saturation:
  - Clamp each component to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - out_ovf = 1 if either component clamped; it is registered with its own result.
- Stall: while out_valid && !out_ready, out_data and out_ovf hold stable and all stages hold. No transaction is lost or duplicated; order is preserved.
- Simultaneous consume and accept in the same cycle is allowed; the pipeline shifts by one.
- in_valid = 0 while adv = 1 inserts a bubble. The result for a bubble is out_valid = 0, with out_data holding its last value.

Optional Feature:
- CMULT_GAUSS3_EN defined:
  - Stage 2 uses the 3-multiplier Gauss form: k1 = br*(ar+ai), k2 = ar*(bi'-br), k3 = ai*(br+bi'); re = k1-k3, im = k1+k2.
  - Pre-adds are done in stage 1 at DATA_W+2 bits.
  - Results, out_ovf, latency and handshake are bit-exact identical to the default.
- Undefined: 4-multiplier form as described above.

Decomposition:
- Shared package cmult_pkg:
  - Component packing helpers (re/im slice functions).
  - Round/saturate function parametrised by widths.
  - Constant PIPE_LAT = 3.
- One natural sub-module: cmult_round_sat, a combinational round-half-up plus saturate for one component, with output flag. Instantiated twice in stage 3.

Test Plan (DATA_W=16, FRAC_W=15):
- a=0x4000_4000, b=0x4000_4000, conj=0 -> out_data=0x0000_4000, ovf=0, 3 cycles after accept.
- Same operands, conj=1 -> out_data=0x4000_0000, ovf=0.
- Rounding: a=0x0001_0000, b=0x4000_0000 -> out_data=0x0001_0000. a=0xFFFF_0000, b=0x4000_0000 -> out_data=0x0000_0000.
- Saturation: a=0x8000_0000, b=0x8000_0000 -> out_data=0x7FFF_0000, ovf=1. Also b=0x0000_8000 with conj=1 (bi'=+1.0), a=0x0000_8000 -> im=-2^15 exact: out_data=0x7FFF_0000 (re=(-1)(+1)... saturated +1), ovf=1.
- Backpressure: stream 8 distinct vectors back-to-back, drop out_ready for 5 cycles mid-stream. Check in_ready=0 during the stall, out_data stable, and all 8 results in order with no loss or duplication. Compare against a reference model, with and without CMULT_GAUSS3_EN.
- Reset: assert rst_n=0 with 3 transactions in flight. Outputs go to 0 immediately, no stale out_valid after release, and the next input completes in 3 cycles.
